esc_pwm_gen: RTL and testbench

Four-channel ESC pulse generator: the consumer of the PID mixer's `pwm_duty_1..4` words. It double-buffers the four duty commands, clamps each to the ESC pulse window, and emits frame-aligned PWM pulses on four motor pins. An arming sequence and a command watchdog keep the motors at idle or off unless fresh, valid commands arrive.

---
 rtl/esc_pwm_gen.sv | 184 ++++++++++++++++++
 tb/tb_esc_pwm_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_pwm_gen.sv
// Four-channel ESC pulse generator: double-buffered, clamped duty commands emitted as
// frame-aligned PWM, gated by an arming sequence and a command watchdog.
module esc_pwm_gen #(
  parameter int unsigned PRESCALE     = 50,
  parameter int unsigned PERIOD_TICKS = 2500,
  parameter int unsigned MIN_PULSE    = 1000,
  parameter int unsigned MAX_PULSE    = 2000,
  parameter int unsigned ARM_FRAMES   = 400,
  parameter int unsigned WDOG_FRAMES  = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        duty_valid,
  input  logic [15:0] duty_1,
  input  logic [15:0] duty_2,
  input  logic [15:0] duty_3,
  input  logic [15:0] duty_4,
  input  logic        arm,
  output logic [3:0]  pwm_out,
  output logic        frame_start,
  output logic        armed,
  output logic        failsafe
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FrmW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int unsigned ArmW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
  localparam int unsigned WdW  = (WDOG_FRAMES > 0) ? $clog2(WDOG_FRAMES + 1) : 1;

  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(PERIOD_TICKS - 1);
  localparam logic [ArmW-1:0] ArmLast = ArmW'(ARM_FRAMES - 1);
  localparam logic [WdW-1:0]  WdMax   = WdW'(WDOG_FRAMES);
  localparam logic [15:0]     MinW    = 16'(MIN_PULSE);
  localparam logic [15:0]     MaxW    = 16'(MAX_PULSE);

  typedef enum logic [1:0] {StDisarmed, StArming, StArmed} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [FrmW-1:0] frame_cnt_q, frame_cnt_d;
  logic [ArmW-1:0] arm_cnt_q, arm_cnt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            pend_flag_q, pend_flag_d;
  logic [15:0]     pend_q [4];
  logic [15:0]     pend_d [4];
  logic [15:0]     act_q [4];
  logic [15:0]     act_d [4];
  logic [15:0]     w_q [4];
  logic [15:0]     w_d [4];
  logic [15:0]     duty_in [4];
  logic [15:0]     duty_clamp [4];
  logic [3:0]      pwm_q, pwm_d;
  logic            frame_start_q, armed_q, armed_d, failsafe_q, failsafe_d;
  logic            tick, bnd;

  always_comb begin
    duty_in[0] = duty_1;
    duty_in[1] = duty_2;
    duty_in[2] = duty_3;
    duty_in[3] = duty_4;
    for (int i = 0; i < 4; i++) begin
      if (duty_in[i] < MinW) begin
        duty_clamp[i] = MinW;
      end else if (duty_in[i] > MaxW) begin
        duty_clamp[i] = MaxW;
      end else begin
        duty_clamp[i] = duty_in[i];
      end
    end
  end

  always_comb begin
    tick        = (pre_cnt_q == PreLast);
    bnd         = tick && (frame_cnt_q == FrmLast);
    pre_cnt_d   = tick ? '0 : pre_cnt_q + PreW'(1);
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = (frame_cnt_q == FrmLast) ? '0 : frame_cnt_q + FrmW'(1);
    end
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    wdog_d      = wdog_q;
    pend_flag_d = pend_flag_q;
    armed_d     = armed_q;
    failsafe_d  = failsafe_q;
    for (int i = 0; i < 4; i++) begin
      pend_d[i] = duty_valid ? duty_clamp[i] : pend_q[i];
      act_d[i]  = act_q[i];
      w_d[i]    = w_q[i];
    end

    if (bnd) begin
      // The transfer uses the previously pending set; a same-cycle sample waits a frame.
      if (pend_flag_q) begin
        for (int i = 0; i < 4; i++) act_d[i] = pend_q[i];
        pend_flag_d = 1'b0;
        wdog_d      = '0;
      end else if (wdog_q != WdMax) begin
        wdog_d = wdog_q + WdW'(1);
      end

      unique case (state_q)
        StDisarmed: begin
          if (arm) begin
            state_d   = StArming;
            arm_cnt_d = '0;
          end
        end
        StArming: begin
          if (!arm) begin
            state_d = StDisarmed;
          end else if (arm_cnt_q == ArmLast) begin
            state_d = StArmed;
            wdog_d  = '0;
            for (int i = 0; i < 4; i++) act_d[i] = MinW;
          end else begin
            arm_cnt_d = arm_cnt_q + ArmW'(1);
          end
        end
        StArmed: begin
          if (!arm) state_d = StDisarmed;
        end
        default: state_d = StDisarmed;
      endcase

      armed_d    = (state_d == StArmed);
      failsafe_d = armed_d && (wdog_d == WdMax);
      for (int i = 0; i < 4; i++) begin
        unique case (state_d)
          StArming: w_d[i] = MinW;
          StArmed:  w_d[i] = failsafe_d ? MinW : act_d[i];
          default:  w_d[i] = '0;
        endcase
      end
    end

    if (duty_valid) pend_flag_d = 1'b1;

    for (int i = 0; i < 4; i++) pwm_d[i] = (16'(frame_cnt_d) < w_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StDisarmed;
      pre_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      arm_cnt_q     <= '0;
      wdog_q        <= '0;
      pend_flag_q   <= 1'b0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      armed_q       <= 1'b0;
      failsafe_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pend_q[i] <= MinW;
        act_q[i]  <= MinW;
        w_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      arm_cnt_q     <= arm_cnt_d;
      wdog_q        <= wdog_d;
      pend_flag_q   <= pend_flag_d;
      pwm_q         <= pwm_d;
      frame_start_q <= bnd;
      armed_q       <= armed_d;
      failsafe_q    <= failsafe_d;
      for (int i = 0; i < 4; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
        w_q[i]    <= w_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign armed       = armed_q;
  assign failsafe    = failsafe_q;

endmodule

// File: tb/tb_esc_pwm_gen.sv
// Bench for esc_pwm_gen: frame-level reference model feeds a scoreboard that a monitor
// drains at every frame_start, measuring each frame's pulse widths and flags.
module tb_esc_pwm_gen;

  localparam int P     = 2;
  localparam int N     = 50;
  localparam int MINP  = 10;
  localparam int MAXP  = 20;
  localparam int ARMF  = 3;
  localparam int WD    = 4;
  localparam int FRAME = P * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        duty_valid = 1'b0;
  logic [15:0] duty_1 = '0, duty_2 = '0, duty_3 = '0, duty_4 = '0;
  logic        arm = 1'b0;
  logic [3:0]  pwm_out;
  logic        frame_start, armed, failsafe;

  always #5 clk = ~clk;

  esc_pwm_gen #(
    .PRESCALE    (P),
    .PERIOD_TICKS(N),
    .MIN_PULSE   (MINP),
    .MAX_PULSE   (MAXP),
    .ARM_FRAMES  (ARMF),
    .WDOG_FRAMES (WD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .duty_valid (duty_valid),
    .duty_1     (duty_1),
    .duty_2     (duty_2),
    .duty_3     (duty_3),
    .duty_4     (duty_4),
    .arm        (arm),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .armed      (armed),
    .failsafe   (failsafe)
  );

  typedef struct packed {
    logic [3:0][15:0] w;
    logic             armed;
    logic             fs;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model, evaluated once per frame boundary.
  int m_run   = 0;  // consecutive boundaries that sampled arm=1
  int m_since = 0;  // boundaries since the last command transfer (saturating)
  bit m_pflag = 0;
  int m_pend [4] = '{MINP, MINP, MINP, MINP};
  int m_act  [4] = '{MINP, MINP, MINP, MINP};
  int n_pushed = 0;

  function automatic int clampd(input int d);
    if (d < MINP) return MINP;
    if (d > MAXP) return MAXP;
    return d;
  endfunction

  task automatic model_capture(input logic [3:0][15:0] d);
    for (int i = 0; i < 4; i++) m_pend[i] = clampd(int'(d[i]));
    m_pflag = 1;
  endtask

  task automatic model_boundary(input bit arm_v);
    exp_t e;
    int   prev_run;
    bit   is_armed;
    if (m_pflag) begin
      m_act   = m_pend;
      m_pflag = 0;
      m_since = 0;
    end else if (m_since < WD) begin
      m_since++;
    end
    prev_run = m_run;
    m_run    = arm_v ? ((m_run > ARMF) ? m_run : m_run + 1) : 0;
    if (prev_run == ARMF && m_run == ARMF + 1) begin
      for (int i = 0; i < 4; i++) m_act[i] = MINP;
      m_since = 0;
    end
    is_armed = (m_run > ARMF);
    e.armed  = is_armed;
    e.fs     = is_armed && (m_since == WD);
    for (int i = 0; i < 4; i++) begin
      if (m_run == 0) e.w[i] = 16'(0);
      else if (!is_armed || e.fs) e.w[i] = 16'(MINP);
      else e.w[i] = 16'(m_act[i]);
    end
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // One frame of stimulus: called on the negedge of a frame's cycle 0.
  task automatic run_frame(input bit arm_v, input int arm_at, input int ka,
                           input logic [3:0][15:0] da, input bit at_bnd,
                           input logic [3:0][15:0] db);
    for (int j = 0; j < FRAME; j++) begin
      if (j == arm_at) arm = arm_v;
      duty_valid = 1'b0;
      if (j == ka) begin
        duty_valid = 1'b1;
        {duty_4, duty_3, duty_2, duty_1} = da;
        model_capture(da);
      end
      if (j == FRAME - 1) begin
        if (at_bnd) begin
          duty_valid = 1'b1;
          {duty_4, duty_3, duty_2, duty_1} = db;
        end
        model_boundary(arm);
        if (at_bnd) model_capture(db);
      end
      @(negedge clk);
    end
    duty_valid = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  bit   mon_en = 0;
  int   cyc = 0, per = 0, n_seen = 0;
  int   cnt [4];
  bit   low_seen [4];
  bit   glitch [4];
  bit   have_cur = 0;
  bit   pre_bad = 0;
  exp_t cur;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      cyc++;
      per++;
      if (frame_start) begin
        if (have_cur) begin
          for (int i = 0; i < 4; i++)
            check($sformatf("width_pin%0d_frame%0d", i, n_seen), glitch[i] ? -1 : cnt[i],
                  int'(cur.w[i]) * P);
          check($sformatf("period_frame%0d", n_seen), per, FRAME);
        end else begin
          check("first_frame_start_cycle", cyc, FRAME);
        end
        per = 0;
        n_seen++;
        check($sformatf("sb_nonempty_frame%0d", n_seen), int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_cur = 1;
          check($sformatf("armed_frame%0d", n_seen), int'(armed), int'(cur.armed));
          check($sformatf("failsafe_frame%0d", n_seen), int'(failsafe), int'(cur.fs));
        end else begin
          have_cur = 0;
        end
        for (int i = 0; i < 4; i++) begin
          cnt[i]      = 0;
          low_seen[i] = 0;
          glitch[i]   = 0;
        end
      end
      if (have_cur) begin
        for (int i = 0; i < 4; i++) begin
          if (pwm_out[i]) begin
            if (low_seen[i]) glitch[i] = 1;
            cnt[i]++;
          end else begin
            low_seen[i] = 1;
          end
        end
      end else if (pwm_out != 4'h0) begin
        pre_bad = 1;
      end
    end
  end

  logic [3:0][15:0] da, db, dz;

  initial begin
    dz = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_armed", int'(armed), 0);
    check("reset_failsafe", int'(failsafe), 0);

    rst_n  = 1'b1;
    mon_en = 1;

    // Disarmed: the lead-in up to the first boundary plus five full frames.
    for (int f = 0; f < 6; f++) run_frame(0, 0, -1, dz, 0, dz);

    // Arming: three idle frames, then armed at MIN until a command arrives.
    for (int f = 0; f < 5; f++) run_frame(1, 0, -1, dz, 0, dz);

    // Clamp: below MIN, in range, above MAX, mixer wrap-around.
    da[0] = 16'd15; da[1] = 16'd5; da[2] = 16'd25; da[3] = 16'hFFF0;
    run_frame(1, 0, int'($urandom_range(0, 90)), da, 0, dz);
    run_frame(1, 0, -1, dz, 0, dz);

    // Pending 18 followed by a boundary-cycle 12.
    for (int i = 0; i < 4; i++) begin
      da[i] = 16'd18;
      db[i] = 16'd12;
    end
    run_frame(1, 0, int'($urandom_range(0, 90)), da, 1, db);
    run_frame(1, 0, -1, dz, 0, dz);
    run_frame(1, 0, -1, dz, 0, dz);

    // Randomized command traffic while armed.
    for (int f = 0; f < 20; f++) begin
      int ka;
      bit bnd_hit;
      for (int i = 0; i < 4; i++) begin
        da[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 30));
        db[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 30));
      end
      ka      = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, FRAME - 2)) : -1;
      bnd_hit = ($urandom_range(0, 4) == 0);
      run_frame(1, 0, ka, da, bnd_hit, db);
    end

    // Command starvation trips the watchdog; a single command recovers.
    for (int f = 0; f < 6; f++) run_frame(1, 0, -1, dz, 0, dz);
    for (int i = 0; i < 4; i++) da[i] = 16'd16;
    run_frame(1, 0, int'($urandom_range(0, 90)), da, 0, dz);
    run_frame(1, 0, -1, dz, 0, dz);

    // Disarm mid-pulse: current pulse completes, pins idle from the next frame.
    run_frame(0, 5, -1, dz, 0, dz);
    run_frame(0, 0, -1, dz, 0, dz);
    run_frame(0, 0, -1, dz, 0, dz);

    // Re-arm, then reset in the middle of an arming pulse.
    run_frame(1, 0, -1, dz, 0, dz);
    run_frame(1, 0, -1, dz, 0, dz);
    repeat (5) @(negedge clk);
    check("pulse_before_reset", int'(pwm_out), 4'hF);
    mon_en = 0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("midpulse_reset_pwm_out", int'(pwm_out), 0);
    check("midpulse_reset_armed", int'(armed), 0);
    check("midpulse_reset_frame_start", int'(frame_start), 0);
    check("midpulse_reset_failsafe", int'(failsafe), 0);

    check("frames_seen", n_seen, n_pushed);
    check("pwm_before_first_frame", int'(pre_bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
